// File: rtl/heavy_part_table_dump_pkg.sv
// Shared definitions for the heavy-part table dump: entry layout, defaults and
// FSM state encodings.
package heavy_part_table_dump_pkg;

  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 96;
  localparam int RD_LAT_DEF    = 2;
  localparam int HOLD_WAIT_DEF = 8;

  localparam int IP_MSB  = 95;
  localparam int IP_LSB  = 64;
  localparam int VAL_MSB = 63;
  localparam int VAL_LSB = 32;
  localparam int CNT_MSB = 31;
  localparam int CNT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_SCAN  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_e;

  // An entry is "empty" only when every field is zero.
  function automatic logic entry_nonzero(input logic [DATA_W_DEF-1:0] e);
    return (|e[IP_MSB:IP_LSB]) | (|e[VAL_MSB:VAL_LSB]) | (|e[CNT_MSB:CNT_LSB]);
  endfunction

endpackage

// File: rtl/heavy_part_table_dump_if.sv
// Bus between the table-dump engine and its RAM / downstream FIFO / control.
// slave = the dump engine, master = the surrounding logic.
interface heavy_part_table_dump_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 96
);
  logic                     dump_start;
  logic                     table_hold;
  logic                     ram_rden;
  logic [ADDR_W-1:0]        ram_rdaddr;
  logic [DATA_W-1:0]        ram_rdvalue;
  logic                     ram_wren;
  logic [ADDR_W-1:0]        ram_wraddr;
  logic [DATA_W-1:0]        ram_wrvalue;
  logic                     entry_out_wr;
  logic [ADDR_W+DATA_W-1:0] entry_out;
  logic                     entry_out_alf;
  logic                     dump_busy;
  logic                     dump_done;
  logic [ADDR_W:0]          entry_count;

  modport slave (
    input  dump_start, ram_rdvalue, entry_out_alf,
    output table_hold, ram_rden, ram_rdaddr, ram_wren, ram_wraddr, ram_wrvalue,
           entry_out_wr, entry_out, dump_busy, dump_done, entry_count
  );

  modport master (
    output dump_start, ram_rdvalue, entry_out_alf,
    input  table_hold, ram_rden, ram_rdaddr, ram_wren, ram_wraddr, ram_wrvalue,
           entry_out_wr, entry_out, dump_busy, dump_done, entry_count
  );
endinterface

// File: rtl/heavy_part_table_dump_rd_pipe.sv
// dump_rd_pipe: DEPTH-deep valid/address delay line that tracks RAM reads in
// flight, with a flag that is high only when nothing is pending or entering.
module heavy_part_table_dump_rd_pipe #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_empty
);

  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_addr [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_addr[0] <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_vld   = r_vld[DEPTH-1];
  assign o_addr  = r_addr[DEPTH-1];
  // The input counts as in flight so a caller sees "empty" only once its
  // last issued read has fully drained.
  assign o_empty = ~i_vld & ~(|r_vld);

endmodule

// File: rtl/heavy_part_table_dump.sv
// Heavy-part table dump: scans every bucket of one heavy-part RAM at epoch end,
// emits non-empty entries tagged with their index and optionally clears them.
//
// state | meaning
// IDLE  | waiting for dump_start
// DRAIN | hold raised, letting in-flight compare-stage writes land
// SCAN  | issuing one read per cycle while the downstream FIFO has room
// FLUSH | all addresses issued, waiting for read returns to drain
// DONE  | one-cycle dump_done pulse, hold released on exit
module heavy_part_table_dump
  import heavy_part_table_dump_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RD_LAT        = RD_LAT_DEF,
  parameter int HOLD_WAIT     = HOLD_WAIT_DEF,
  parameter int CLEAR_ON_READ = 1
) (
  input logic                    i_clk,
  input logic                    i_reset,
  heavy_part_table_dump_if.slave io_bus
);

  localparam int                DRAIN_W    = (HOLD_WAIT > 0) ? $clog2(HOLD_WAIT + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(HOLD_WAIT);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = '1;

  dump_state_e              r_state;
  logic [DRAIN_W-1:0]       r_drain;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_rden;
  logic [ADDR_W-1:0]        r_rdaddr;
  logic                     r_wren;
  logic [ADDR_W-1:0]        r_wraddr;
  logic                     r_out_wr;
  logic [ADDR_W+DATA_W-1:0] r_out;
  logic [ADDR_W:0]          r_count;
  logic                     r_hold;
  logic                     r_done;

  logic                     w_ret_vld;
  logic [ADDR_W-1:0]        w_ret_addr;
  logic                     w_pipe_empty;
  logic                     w_ret_nz;

  heavy_part_table_dump_rd_pipe #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RD_LAT)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_vld   (r_rden),
    .i_addr  (r_rdaddr),
    .o_vld   (w_ret_vld),
    .o_addr  (w_ret_addr),
    .o_empty (w_pipe_empty)
  );

  assign w_ret_nz = entry_nonzero(io_bus.ram_rdvalue);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_drain  <= '0;
      r_addr   <= '0;
      r_rden   <= 1'b0;
      r_rdaddr <= '0;
      r_wren   <= 1'b0;
      r_wraddr <= '0;
      r_out_wr <= 1'b0;
      r_out    <= '0;
      r_count  <= '0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rden   <= 1'b0;
      r_wren   <= 1'b0;
      r_out_wr <= 1'b0;
      r_done   <= 1'b0;

      // Returns are emitted unconditionally; the FIFO's alf margin covers
      // everything still in the read pipeline when alf rises.
      if (w_ret_vld) begin
        if (w_ret_nz) begin
          r_out_wr <= 1'b1;
          r_out    <= {w_ret_addr, io_bus.ram_rdvalue};
          r_count  <= r_count + 1'b1;
        end
        if (CLEAR_ON_READ != 0) begin
          r_wren   <= 1'b1;
          r_wraddr <= w_ret_addr;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (io_bus.dump_start) begin
            r_state <= ST_DRAIN;
            r_hold  <= 1'b1;
            r_drain <= DRAIN_LOAD;
            r_count <= '0;
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_SCAN;
            r_addr  <= '0;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        ST_SCAN: begin
          if (!io_bus.entry_out_alf) begin
            r_rden   <= 1'b1;
            r_rdaddr <= r_addr;
            r_addr   <= r_addr + 1'b1;
            if (r_addr == ADDR_LAST) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_pipe_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_hold  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.table_hold   = r_hold;
  assign io_bus.dump_busy    = r_hold;
  assign io_bus.ram_rden     = r_rden;
  assign io_bus.ram_rdaddr   = r_rdaddr;
  assign io_bus.ram_wren     = r_wren;
  assign io_bus.ram_wraddr   = r_wraddr;
  assign io_bus.ram_wrvalue  = '0;
  assign io_bus.entry_out_wr = r_out_wr;
  assign io_bus.entry_out    = r_out;
  assign io_bus.dump_done    = r_done;
  assign io_bus.entry_count  = r_count;

endmodule

// File: tb/tb_heavy_part_table_dump.sv
// Directed bench for heavy_part_table_dump: one clearing instance and one
// read-only instance, each with a behavioural 2-cycle-latency RAM.
module tb_heavy_part_table_dump;

  localparam int AW = 12;
  localparam int DW = 96;
  localparam int NB = 4096;
  localparam int HW = 8;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  heavy_part_table_dump_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  heavy_part_table_dump_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  heavy_part_table_dump #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .HOLD_WAIT(HW), .CLEAR_ON_READ(1)
  ) dut0 (.i_clk(clk), .i_reset(rst_n), .io_bus(if0.slave));

  heavy_part_table_dump #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .HOLD_WAIT(HW), .CLEAR_ON_READ(0)
  ) dut1 (.i_clk(clk), .i_reset(rst_n), .io_bus(if1.slave));

  logic [DW-1:0] mem0 [NB];
  logic [DW-1:0] mem1 [NB];
  logic [DW-1:0] gold [NB];
  logic [DW-1:0] rd0_s1, rd1_s1;

  // RAM models: read data appears RL cycles after the cycle ram_rden is high.
  always @(posedge clk) begin
    rd0_s1 <= mem0[if0.ram_rdaddr];
    if0.ram_rdvalue <= rd0_s1;
    rd1_s1 <= mem1[if1.ram_rdaddr];
    if1.ram_rdvalue <= rd1_s1;
    if (if0.ram_wren) mem0[if0.ram_wraddr] = if0.ram_wrvalue;
    if (if1.ram_wren) mem1[if1.ram_wraddr] = if1.ram_wrvalue;
  end

  int n_rd = 0, n_wr = 0, n_out = 0, n_bad = 0, n_ord = 0, n_alf = 0, n_done = 0, n_hold = 0;
  int n_out1 = 0, n_wr1 = 0, n_bad1 = 0, n_done1 = 0;
  int last_idx = -1;
  logic alf_prev = 1'b0;
  logic [AW+DW-1:0] first_out, last_out;

  always @(negedge clk) begin
    if (if0.ram_rden) begin
      n_rd++;
      if (alf_prev) n_alf++;
    end
    alf_prev = if0.entry_out_alf;
    if (if0.ram_wren) n_wr++;
    if (if0.dump_done) n_done++;
    if (if0.table_hold) n_hold++;
    else last_idx = -1;
    if (if0.entry_out_wr) begin
      if (last_idx < 0) first_out = if0.entry_out;
      last_out = if0.entry_out;
      if (if0.entry_out[DW-1:0] !== gold[if0.entry_out[AW+DW-1:DW]]) n_bad++;
      if (int'(if0.entry_out[AW+DW-1:DW]) <= last_idx) n_ord++;
      last_idx = int'(if0.entry_out[AW+DW-1:DW]);
      n_out++;
    end
    if (if1.ram_wren) n_wr1++;
    if (if1.dump_done) n_done1++;
    if (if1.entry_out_wr) begin
      if (if1.entry_out[DW-1:0] !== gold[if1.entry_out[AW+DW-1:DW]]) n_bad1++;
      n_out1++;
    end
  end

  int checks = 0;
  int errors = 0;
  int b_rd, b_wr, b_out, b_bad, b_ord, b_alf, b_done, b_hold;
  int b_out1, b_wr1, b_bad1, b_done1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rd = n_rd; b_wr = n_wr; b_out = n_out; b_bad = n_bad; b_ord = n_ord;
    b_alf = n_alf; b_done = n_done; b_hold = n_hold;
    b_out1 = n_out1; b_wr1 = n_wr1; b_bad1 = n_bad1; b_done1 = n_done1;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NB; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
      gold[i] = '0;
    end
  endtask

  task automatic chk_rst_outs(input string p);
    chk({p, "_hold"},   128'(if0.table_hold), 128'd0);
    chk({p, "_busy"},   128'(if0.dump_busy), 128'd0);
    chk({p, "_rden"},   128'(if0.ram_rden), 128'd0);
    chk({p, "_rdaddr"}, 128'(if0.ram_rdaddr), 128'd0);
    chk({p, "_wren"},   128'(if0.ram_wren), 128'd0);
    chk({p, "_outwr"},  128'(if0.entry_out_wr), 128'd0);
    chk({p, "_out"},    128'(if0.entry_out), 128'd0);
    chk({p, "_done"},   128'(if0.dump_done), 128'd0);
    chk({p, "_count"},  128'(if0.entry_count), 128'd0);
    chk({p, "_wrval"},  128'(if0.ram_wrvalue), 128'd0);
  endtask

  // Starts a scan on instance d and waits (bounded) for dump_done.
  // tog toggles entry_out_alf 50 cycles on / 50 off; repulse re-pulses start.
  task automatic do_scan(input int d, input bit tog, input int repulse);
    int  i;
    bit  seen;
    if (d == 0) if0.dump_start = 1'b1;
    else        if1.dump_start = 1'b1;
    @(posedge clk); #1;
    if0.dump_start = 1'b0;
    if1.dump_start = 1'b0;
    seen = 1'b0;
    i = 0;
    while (!seen && i < 20000) begin
      if (tog) if0.entry_out_alf = (((i / 50) % 2) == 1);
      if (d == 0) if0.dump_start = (i == repulse);
      @(posedge clk); #1;
      i++;
      seen = (d == 0) ? if0.dump_done : if1.dump_done;
    end
    if0.entry_out_alf = 1'b0;
    if0.dump_start = 1'b0;
    chk("scan_done_seen", 128'(seen), 128'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int nz;
  bit found;

  initial begin
    if0.dump_start = 1'b0; if0.entry_out_alf = 1'b0;
    if1.dump_start = 1'b0; if1.entry_out_alf = 1'b0;
    clear_tables();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_rst_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All-zero table
    snap();
    do_scan(0, 1'b0, -1);
    chk("zero_reads",  128'(n_rd - b_rd), 128'd4096);
    chk("zero_clears", 128'(n_wr - b_wr), 128'd4096);
    chk("zero_outs",   128'(n_out - b_out), 128'd0);
    chk("zero_done",   128'(n_done - b_done), 128'd1);
    chk("zero_count",  128'(if0.entry_count), 128'd0);
    chk("zero_hold",   128'(n_hold - b_hold), 128'(HW + 1 + 4096 + RL + 2 + 1));
    chk("zero_busy_after", 128'(if0.dump_busy), 128'd0);

    // First and last bucket populated
    gold[0]    = {32'h0A000001, 32'd5, 32'd1};
    gold[4095] = {32'hC0A80101, 32'd9, 32'd0};
    mem0[0] = gold[0];
    mem0[4095] = gold[4095];
    snap();
    do_scan(0, 1'b0, -1);
    chk("edge_outs",  128'(n_out - b_out), 128'd2);
    chk("edge_bad",   128'(n_bad - b_bad), 128'd0);
    chk("edge_first", 128'(first_out), 128'({12'h000, 32'h0A000001, 32'd5, 32'd1}));
    chk("edge_last",  128'(last_out),  128'({12'hFFF, 32'hC0A80101, 32'd9, 32'd0}));
    chk("edge_count", 128'(if0.entry_count), 128'd2);
    chk("edge_clr0",  128'(mem0[0]), 128'd0);
    chk("edge_clr4095", 128'(mem0[4095]), 128'd0);

    // Full table, alf toggling, extra dump_start mid-scan
    for (int i = 0; i < NB; i++) begin
      gold[i] = {32'(i) ^ 32'hA5000000, 32'(i * 3 + 1), 32'(i + 7)};
      mem0[i] = gold[i];
    end
    snap();
    do_scan(0, 1'b1, 3000);
    chk("full_outs",  128'(n_out - b_out), 128'd4096);
    chk("full_bad",   128'(n_bad - b_bad), 128'd0);
    chk("full_order", 128'(n_ord - b_ord), 128'd0);
    chk("full_alf",   128'(n_alf - b_alf), 128'd0);
    chk("full_reads", 128'(n_rd - b_rd), 128'd4096);
    chk("full_done",  128'(n_done - b_done), 128'd1);
    chk("full_count", 128'(if0.entry_count), 128'd4096);
    chk("full_first", 128'(first_out), 128'({12'h000, 32'hA5000000, 32'd1, 32'd7}));
    chk("full_last",  128'(last_out),  128'({12'hFFF, 32'hA5000FFF, 32'd12286, 32'd4102}));
    nz = 0;
    for (int i = 0; i < NB; i++) if (mem0[i] != '0) nz++;
    chk("full_cleared", 128'(nz), 128'd0);

    // Read-only instance, scanned twice
    clear_tables();
    gold[7]    = {32'h01020304, 32'd11, 32'd2};
    gold[100]  = {32'h00000000, 32'd0, 32'd1};
    gold[4000] = {32'hFFFFFFFF, 32'd3, 32'd0};
    mem1[7] = gold[7];
    mem1[100] = gold[100];
    mem1[4000] = gold[4000];
    for (int s = 0; s < 2; s++) begin
      snap();
      do_scan(1, 1'b0, -1);
      chk("ro_outs",  128'(n_out1 - b_out1), 128'd3);
      chk("ro_bad",   128'(n_bad1 - b_bad1), 128'd0);
      chk("ro_wren",  128'(n_wr1 - b_wr1), 128'd0);
      chk("ro_done",  128'(n_done1 - b_done1), 128'd1);
      chk("ro_count", 128'(if1.entry_count), 128'd3);
    end

    // Reset while scanning address 1000
    clear_tables();
    gold[500]  = {32'h0B0B0B0B, 32'd1, 32'd1};
    gold[2000] = {32'h0C0C0C0C, 32'd2, 32'd2};
    mem0[500] = gold[500];
    mem0[2000] = gold[2000];
    if0.dump_start = 1'b1;
    @(posedge clk); #1;
    if0.dump_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (if0.ram_rden && if0.ram_rdaddr == 12'd1000) found = 1'b1;
    end
    chk("abort_reached1000", 128'(found), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_rst_outs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_tables();
    gold[3]    = {32'h0D000003, 32'd4, 32'd4};
    gold[2000] = {32'h0E0007D0, 32'd8, 32'd8};
    mem0[3] = gold[3];
    mem0[2000] = gold[2000];
    snap();
    do_scan(0, 1'b0, -1);
    chk("restart_reads", 128'(n_rd - b_rd), 128'd4096);
    chk("restart_outs",  128'(n_out - b_out), 128'd2);
    chk("restart_first", 128'(first_out), 128'({12'd3, 32'h0D000003, 32'd4, 32'd4}));
    chk("restart_last",  128'(last_out),  128'({12'd2000, 32'h0E0007D0, 32'd8, 32'd8}));
    chk("restart_count", 128'(if0.entry_count), 128'd2);
    chk("restart_done",  128'(n_done - b_done), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heavy_part_table_dump.md
Name: heavy_part_table_dump

Overview:
- Read-side counterpart to the heavy-part compare/update stage. At the end of a measurement epoch it scans every bucket of one heavy-part RAM and emits each non-empty entry downstream, tagged with its bucket index.
- Optionally clears each bucket as it is read, so the table starts empty for the next epoch.
- Sits beside the compare stage on the same RAM. While busy it asserts a hold so the compare stage stops issuing updates.

Parameters:
- ADDR_W, 12: bucket index width; the table holds 2^ADDR_W buckets.
- DATA_W, 96: entry width; layout is [95:64] ip addr, [63:32] value, [31:0] counter.
- RD_LAT, 2: RAM read latency in cycles, from ram_rdaddr/ram_rden to valid ram_rdvalue.
- HOLD_WAIT, 8: drain cycles after table_hold rises and before the first read, so in-flight compare-stage writes complete.
- CLEAR_ON_READ, 1: 1 = write zero to each bucket after reading it; 0 = read-only scan.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- dump_start  in  1  single-cycle request to start a scan.
- table_hold  out  1  high from accept of dump_start until dump_done; OR'd into the compare stage's downstream almost-full input.
- ram_rden  out  1  RAM read enable.
- ram_rdaddr  out  ADDR_W  RAM read address.
- ram_rdvalue  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_rden.
- ram_wren  out  1  RAM clear-write enable.
- ram_wraddr  out  ADDR_W  RAM clear-write address.
- ram_wrvalue  out  DATA_W  RAM write data; always zero.
- entry_out_wr  out  1  output entry valid strobe.
- entry_out  out  ADDR_W+DATA_W  {bucket index, entry}.
- entry_out_alf  in  1  downstream FIFO almost-full; asserts with at least RD_LAT+2 free words.
- dump_busy  out  1  scan in progress.
- dump_done  out  1  single-cycle pulse at scan completion.
- entry_count  out  ADDR_W+1  non-empty entries emitted in the last or current scan.

Behaviour:
- Reset (async, active-low): all outputs are 0, state is IDLE, address counter and in-flight pipeline are cleared. entry_count is 0.
- Reset mid-scan aborts the scan immediately. The table may be left partially cleared; this is accepted.
- IDLE:
  - On dump_start=1: table_hold and dump_busy go 1 next cycle, entry_count clears to 0, drain counter loads HOLD_WAIT, go to DRAIN.
  - dump_start in any other state is ignored.
- DRAIN: decrement the drain counter each cycle; at 0, go to SCAN with addr=0.
- SCAN:
  - Each cycle with entry_out_alf=0: ram_rden=1 and ram_rdaddr=addr, then addr increments.
  - With entry_out_alf=1: ram_rden=0 and addr holds.
  - After issuing addr = 2^ADDR_W-1, go to FLUSH; the address wraps to 0 and is not reissued.
- Return pipeline: an RD_LAT-deep shift register carries valid and addr for each issued read. When a slot reaches the end (RD_LAT cycles after issue):
  - If ram_rdvalue != 0: entry_out_wr=1, entry_out={addr, ram_rdvalue}, entry_count+1.
  - In-flight returns are always emitted regardless of entry_out_alf; the alf margin covers them.
  - If CLEAR_ON_READ=1: in the same cycle ram_wren=1, ram_wraddr=addr, ram_wrvalue=0, issued for zero entries too.
- FLUSH: wait until the pipeline valid bits are all 0, then go to DONE.
- DONE: one cycle with dump_done=1. table_hold and dump_busy drop to 0 next cycle. Return to IDLE. entry_count holds its value until the next start.
- Registered outputs:
  - ram_rden/ram_rdaddr are registered; RD_LAT is measured from the cycle ram_rden is high at the RAM.
  - entry_out_wr and ram_wren are registered strobes, high for exactly one cycle per entry.
- Width rules: entry_count saturates at 2^ADDR_W (a full table), so it needs no overflow handling. The address counter is ADDR_W bits.
- Simultaneous events: a read issue and a clear-write on different addresses in the same cycle is legal; the RAM is dual-port. A clear-write always targets an address already read, never one still pending.

Decomposition:
- Shared package: entry field offsets (IP_MSB/LSB, VAL_MSB/LSB, CNT_MSB/LSB), DATA_W and ADDR_W defaults, state encodings (IDLE, DRAIN, SCAN, FLUSH, DONE).
- One sub-module: dump_rd_pipe, the RD_LAT-deep valid/address delay line with an all-empty flag. It is reusable for the other heavy-part tables.

Test Plan:
- All-zero RAM, dump_start -> 4096 reads, no entry_out_wr, 4096 clear-writes, dump_done once, entry_count=0, table_hold high for HOLD_WAIT+4096+RD_LAT+~3 cycles.
- Entries at bucket 0 {0x0A000001,5,1} and bucket 4095 {0xC0A80101,9,0} -> exactly two outputs: {0x000,...} and {0xFFF,...}; entry_count=2; both buckets read 0 afterwards.
- Full table (all nonzero) with entry_out_alf toggling 50 cycles on / 50 off -> 4096 outputs, none lost, strictly ascending index, no read issued while alf=1.
- dump_start pulsed again mid-SCAN -> ignored; single dump_done; entry_count is unchanged by the extra pulse.
- CLEAR_ON_READ=0, 3 seeded entries -> 3 outputs, ram_wren never high, a second scan reproduces the same 3 outputs.
- reset deasserted→asserted low at addr 1000 -> all outputs 0 same edge; after release a new scan starts cleanly from addr 0 and entry_count counts only the new scan.
